// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory port arbiter
package imem_arb_pkg;
    typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_FETCH_MIS, OWN_LOAD_RD} owner_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-macro signals of the shared instruction-memory port
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_misalign;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              l_lock;
    logic              l_locked;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_misalign, l_gnt, l_rvalid, l_rdata, l_locked,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_misalign, l_gnt, l_rvalid, l_rdata, l_locked,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single instruction-memory port between fetch and the loader,
// with starvation protection and an exclusive locked loader session
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst,
    imem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    state_t state;
    owner_t owner;
    logic [CNT_W-1:0] starve;
    logic fetch_wins, misalign, f_gnt, l_gnt, f_mem;
    logic unused_addr;
    assign unused_addr = ^bus.f_addr[31:ADDR_W+2];
    // Fetch loses while a lock is being requested and once the waiting loader has starved long enough
    always_comb begin
        fetch_wins = state == ST_ARB && !bus.l_lock && !(bus.l_req && starve == LIMIT);
        misalign = bus.f_addr[1:0] != 2'b00;
        f_gnt = !rst && bus.f_req && fetch_wins;
        l_gnt = !rst && bus.l_req && !f_gnt;
        f_mem = f_gnt && !misalign;
    end
    assign bus.f_gnt = f_gnt;
    assign bus.l_gnt = l_gnt;
    assign bus.mem_en = f_mem || l_gnt;
    assign bus.mem_we = l_gnt && bus.l_we;
    assign bus.mem_addr = f_mem ? bus.f_addr[ADDR_W+1:2] : l_gnt ? bus.l_addr : '0;
    assign bus.mem_wdata = l_gnt && bus.l_we ? bus.l_wdata : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARB;
            owner <= OWN_NONE;
            starve <= '0;
        end else begin
            unique case (state)
                ST_ARB:   state <= bus.l_lock ? ST_DRAIN : ST_ARB;
                ST_DRAIN: state <= ST_LOCKED;
                default:  state <= bus.l_lock ? ST_LOCKED : ST_ARB;
            endcase
            owner <= f_gnt ? (misalign ? OWN_FETCH_MIS : OWN_FETCH)
                   : (l_gnt && !bus.l_we) ? OWN_LOAD_RD : OWN_NONE;
            if (l_gnt)
                starve <= '0;
            else if (f_gnt && bus.l_req && starve != LIMIT)
                starve <= starve + 1'b1;
        end
    end
    // Responses are masked during reset so an in-flight read never surfaces
    assign bus.f_rvalid = !rst && (owner == OWN_FETCH || owner == OWN_FETCH_MIS);
    assign bus.f_misalign = !rst && owner == OWN_FETCH_MIS;
    assign bus.f_rdata = rst ? '0 : owner == OWN_FETCH ? bus.mem_rdata
                       : owner == OWN_FETCH_MIS ? DATA_W'(NOP) : '0;
    assign bus.l_rvalid = !rst && owner == OWN_LOAD_RD;
    assign bus.l_rdata = !rst && owner == OWN_LOAD_RD ? bus.mem_rdata : '0;
    assign bus.l_locked = !rst && state == ST_LOCKED;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and random stimulus against a cycle-level reference model of the
// arbiter's rules, with a behavioural 1024x32 synchronous memory attached to the port
module tb_imem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LIM = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ref_mem [1024];
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end
    // Reference model: mode 0=arbitrate 1=drain 2=locked; pend 0=none 1=fetch 2=misaligned 3=loader read
    int mode, cnt, pend;
    logic [31:0] pdata;
    int vectors, errors;
    logic lk_r;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic r, input logic fr, input logic [31:0] fa, input logic lr,
                        input logic lw, input logic [9:0] la, input logic [31:0] lwd,
                        input logic lk);
        logic fg, lg, al;
        logic [9:0] fw;
        @(negedge clk);
        rst = r;
        bus.f_req = fr;
        bus.f_addr = fa;
        bus.l_req = lr;
        bus.l_we = lw;
        bus.l_addr = la;
        bus.l_wdata = lwd;
        bus.l_lock = lk;
        #1;
        al = fa[1:0] == 2'b00;
        fw = fa[11:2];
        fg = !r && fr && mode == 0 && !lk && !(lr && cnt == LIM);
        lg = !r && lr && !fg;
        chk("f_gnt", 32'(bus.f_gnt), 32'(fg));
        chk("l_gnt", 32'(bus.l_gnt), 32'(lg));
        chk("mem_en", 32'(bus.mem_en), 32'((fg && al) || lg));
        chk("mem_we", 32'(bus.mem_we), 32'(lg && lw));
        chk("mem_addr", 32'(bus.mem_addr), 32'((fg && al) ? fw : lg ? la : 10'd0));
        chk("mem_wdata", bus.mem_wdata, (lg && lw) ? lwd : 32'd0);
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(!r && (pend == 1 || pend == 2)));
        chk("f_misalign", 32'(bus.f_misalign), 32'(!r && pend == 2));
        chk("f_rdata", bus.f_rdata, r ? 32'd0 : pend == 1 ? pdata : pend == 2 ? 32'h13 : 32'd0);
        chk("l_rvalid", 32'(bus.l_rvalid), 32'(!r && pend == 3));
        chk("l_rdata", bus.l_rdata, (!r && pend == 3) ? pdata : 32'd0);
        chk("l_locked", 32'(bus.l_locked), 32'(!r && mode == 2));
        @(posedge clk);
        if (r) begin
            mode = 0;
            cnt = 0;
            pend = 0;
        end else begin
            pend = fg ? (al ? 1 : 2) : (lg && !lw) ? 3 : 0;
            pdata = (fg && al) ? ref_mem[fw] : ref_mem[la];
            if (lg && lw)
                ref_mem[la] = lwd;
            cnt = lg ? 0 : (fg && lr && cnt < LIM) ? cnt + 1 : cnt;
            mode = mode == 0 ? (lk ? 1 : 0) : mode == 1 ? 2 : (lk ? 2 : 0);
        end
    endtask
    task automatic idle(input logic lk);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, lk);
    endtask
    initial begin
        logic [31:0] fa;
        vectors = 0;
        errors = 0;
        mode = 0;
        cnt = 0;
        pend = 0;
        pdata = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        rst = 1'b1;
        bus.f_req = 1'b0;
        bus.f_addr = '0;
        bus.l_req = 1'b0;
        bus.l_we = 1'b0;
        bus.l_addr = '0;
        bus.l_wdata = '0;
        bus.l_lock = 1'b0;
        bus.mem_rdata = '0;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'd4, 1'b1, 1'b1, 10'd2, 32'h55, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 11; i++)
            step(1'b0, 1'b1, 32'(8 + 4 * i), 1'b1, 1'b0, 10'd7, 32'd0, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        #1;
        chk("misalign_nop", bus.f_rdata, 32'h13);
        idle(1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
        #1;
        chk("locked_3rd", 32'(bus.l_locked), 32'd1);
        step(1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b1);
        idle(1'b0);
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        #1;
        chk("raw_fetch", bus.f_rdata, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b0);
        #1;
        chk("ld_rd3", bus.l_rdata, 32'd3 * 32'h9E37_79B9);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h24, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0);
        idle(1'b0);
        lk_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0)
                lk_r = ~lk_r;
            fa = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0,
                  10'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7, fa,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 15)), $urandom, lk_r);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
